// File: rtl/reg_scoreboard_checker_pkg.sv
// Shared constants and types for the issue-side register scoreboard.
// Register count, index width and the stall watchdog FSM encoding live here.
package reg_scoreboard_checker_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      DEADLOCK = 2'd2
   } state_t;

endpackage : reg_scoreboard_checker_pkg

// File: rtl/reg_scoreboard_checker_if.sv
// Decode-to-scoreboard bundle: issue request, writeback notification and flush.
// Handshake: an instruction issues on a rising edge where issue_valid and issue_ready are both 1.
interface reg_scoreboard_checker_if;
   import reg_scoreboard_checker_pkg::*;

   logic                 issue_valid;
   logic [REG_IDX_W-1:0] issue_rs;
   logic [REG_IDX_W-1:0] issue_rt;
   logic                 issue_uses_rt;
   logic [REG_IDX_W-1:0] issue_rd;
   logic                 issue_writes_rd;
   logic                 issue_ready;
   logic                 wb_valid;
   logic [REG_IDX_W-1:0] wb_rd;
   logic                 flush;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_rd, issue_writes_rd,
      output wb_valid, wb_rd, flush,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_rd, issue_writes_rd,
      input  wb_valid, wb_rd, flush,
      output issue_ready
   );

endinterface : reg_scoreboard_checker_if

// File: rtl/reg_scoreboard_checker_sb_hazard_check.sv
// Combinational RAW/WAW hazard check against the busy flags.
// A writeback completing this cycle releases its register to the checker immediately.
module sb_hazard_check
   import reg_scoreboard_checker_pkg::*;
(
   input  logic [NUM_REGS-1:0]  busy_vec,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [REG_IDX_W-1:0] issue_rs,
   input  logic [REG_IDX_W-1:0] issue_rt,
   input  logic                 issue_uses_rt,
   input  logic [REG_IDX_W-1:0] issue_rd,
   input  logic                 issue_writes_rd,
   input  logic                 flush,
   output logic                 issue_ready
);

   logic [NUM_REGS-1:0] wb_mask;
   logic [NUM_REGS-1:0] eff_busy;

   always_comb begin
      wb_mask = '0;
      if (wb_valid) begin
         wb_mask[wb_rd] = 1'b1;
      end
      eff_busy    = busy_vec & ~wb_mask;
      issue_ready = ~flush
                  & ~eff_busy[issue_rs]
                  & ~(issue_uses_rt & eff_busy[issue_rt])
                  & ~(issue_writes_rd & eff_busy[issue_rd]);
   end

endmodule : sb_hazard_check

// File: rtl/reg_scoreboard_checker.sv
// Register scoreboard: busy flags set on issue, cleared on writeback, plus a
// stall watchdog that raises a sticky deadlock flag after TIMEOUT stalled cycles.
module reg_scoreboard_checker
   import reg_scoreboard_checker_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   reg_scoreboard_checker_if.slave bus,
   output logic [NUM_REGS-1:0]     busy_vec,
   output logic                    stall,
   output logic [CNT_W-1:0]        stall_count,
   output logic                    deadlock,
   output state_t                  state
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic                ready;
   logic                fire;
   logic [NUM_REGS-1:0] busy_next;
   state_t              state_next;
   logic [CNT_W-1:0]    count_next;
   logic                deadlock_next;

   sb_hazard_check u_hazard (
      .busy_vec        (busy_vec),
      .wb_valid        (bus.wb_valid),
      .wb_rd           (bus.wb_rd),
      .issue_rs        (bus.issue_rs),
      .issue_rt        (bus.issue_rt),
      .issue_uses_rt   (bus.issue_uses_rt),
      .issue_rd        (bus.issue_rd),
      .issue_writes_rd (bus.issue_writes_rd),
      .flush           (bus.flush),
      .issue_ready     (ready)
   );

   assign bus.issue_ready = ready;
   assign fire            = bus.issue_valid & ready;
   assign stall           = bus.issue_valid & ~ready;

   // Set is applied after clear so a new producer keeps ownership of its rd.
   always_comb begin
      busy_next = busy_vec;
      if (bus.wb_valid) begin
         busy_next[bus.wb_rd] = 1'b0;
      end
      if (fire && bus.issue_writes_rd) begin
         busy_next[bus.issue_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
      if (bus.flush) begin
         busy_next = '0;
      end
   end

   always_comb begin
      state_next    = state;
      count_next    = stall_count;
      deadlock_next = deadlock;
      case (state)
         RUN: begin
            if (stall) begin
               state_next = STALL;
               count_next = ONE_C;
            end else begin
               count_next = '0;
            end
         end
         STALL: begin
            if (stall) begin
               count_next = stall_count + ONE_C;
               if (stall_count + ONE_C == TIMEOUT_C) begin
                  state_next    = DEADLOCK;
                  deadlock_next = 1'b1;
               end
            end else begin
               state_next = RUN;
               count_next = '0;
            end
         end
         DEADLOCK: begin
            // Deadlock stays sticky even once the stuck instruction finally issues.
            if (stall) begin
               count_next = TIMEOUT_C;
            end else begin
               state_next = RUN;
               count_next = '0;
            end
         end
         default: begin
            state_next = RUN;
            count_next = '0;
         end
      endcase
      if (bus.flush) begin
         state_next    = RUN;
         count_next    = '0;
         deadlock_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_vec    <= '0;
         state       <= RUN;
         stall_count <= '0;
         deadlock    <= 1'b0;
      end else begin
         busy_vec    <= busy_next;
         state       <= state_next;
         stall_count <= count_next;
         deadlock    <= deadlock_next;
      end
   end

endmodule : reg_scoreboard_checker

// File: tb/tb_reg_scoreboard_checker.sv
// Bench for reg_scoreboard_checker: directed hazard/bypass/watchdog/reset steps,
// then randomized traffic, all checked against a register-array reference model.
module tb_reg_scoreboard_checker;
   import reg_scoreboard_checker_pkg::*;

   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 8;

   logic                clk;
   logic                reset;
   logic [NUM_REGS-1:0] busy_vec;
   logic                stall;
   logic [CNT_W-1:0]    stall_count;
   logic                deadlock;
   state_t              dbg_state;

   int checks = 0;
   int errors = 0;

   // Reference model: busy flags, length of the current stall run, sticky flag.
   bit [NUM_REGS-1:0] m_busy;
   int                m_run;
   bit                m_dead;

   reg_scoreboard_checker_if bus ();

   reg_scoreboard_checker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy_vec    (busy_vec),
      .stall       (stall),
      .stall_count (stall_count),
      .deadlock    (deadlock),
      .state       (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input bit urt,
                        input int rd, input bit wr, input bit wbv, input int wbr,
                        input bit fl);
      bus.issue_valid     = v;
      bus.issue_rs        = REG_IDX_W'(rs);
      bus.issue_rt        = REG_IDX_W'(rt);
      bus.issue_uses_rt   = urt;
      bus.issue_rd        = REG_IDX_W'(rd);
      bus.issue_writes_rd = wr;
      bus.wb_valid        = wbv;
      bus.wb_rd           = REG_IDX_W'(wbr);
      bus.flush           = fl;
   endtask

   task automatic model_reset();
      m_busy = '0;
      m_run  = 0;
      m_dead = 1'b0;
   endtask

   // One clock cycle: check the combinational outputs, advance the model,
   // then check the registered outputs just after the edge.
   task automatic cycle(input string tag);
      bit [NUM_REGS-1:0] eff;
      bit exp_ready, exp_stall, exp_fire;
      int exp_cnt;
      #1;
      eff = m_busy;
      if (bus.wb_valid) eff[bus.wb_rd] = 1'b0;
      exp_ready = !bus.flush && !eff[bus.issue_rs]
                  && !(bus.issue_uses_rt && eff[bus.issue_rt])
                  && !(bus.issue_writes_rd && eff[bus.issue_rd]);
      exp_stall = bus.issue_valid && !exp_ready;
      exp_fire  = bus.issue_valid && exp_ready;
      if (bus.issue_valid) check({tag, ".ready"}, 64'(bus.issue_ready), 64'(exp_ready));
      check({tag, ".stall"}, 64'(stall), 64'(exp_stall));
      if (bus.flush) begin
         model_reset();
      end else begin
         if (bus.wb_valid) m_busy[bus.wb_rd] = 1'b0;
         if (exp_fire && bus.issue_writes_rd && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
         m_run = exp_stall ? m_run + 1 : 0;
         if (m_run >= TIMEOUT) m_dead = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_cnt = (m_run > TIMEOUT) ? TIMEOUT : m_run;
      check({tag, ".busy_vec"}, 64'(busy_vec), 64'(m_busy));
      check({tag, ".stall_count"}, 64'(stall_count), 64'(exp_cnt));
      check({tag, ".deadlock"}, 64'(deadlock), 64'(m_dead));
   endtask

   initial begin
      int wbr, pick;
      bit wbv;
      int busy_list[$];

      // Reset
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy_vec", 64'(busy_vec), 64'h0);
      check("reset.stall_count", 64'(stall_count), 64'h0);
      check("reset.deadlock", 64'(deadlock), 64'h0);
      check("reset.state", 64'(dbg_state), 64'(RUN));
      reset = 1'b1;
      @(posedge clk);
      #1;

      // RAW hazard on r5, then released by a same-cycle writeback
      drive(1, 1, 2, 1, 5, 1, 0, 0, 0); cycle("issue_r5");
      check("r5_busy", 64'(busy_vec), 64'h20);
      drive(1, 5, 0, 0, 6, 1, 0, 0, 0); cycle("raw_r5_a");
      check("raw_stall_count", 64'(stall_count), 64'd1);
      drive(1, 5, 0, 0, 6, 1, 0, 0, 0); cycle("raw_r5_b");
      drive(1, 5, 0, 0, 6, 1, 1, 5, 0);
      #1;
      check("bypass_ready", 64'(bus.issue_ready), 64'h1);
      cycle("bypass_r5");
      check("after_bypass", 64'(busy_vec), 64'h40);

      // WAW on r7 with same-cycle writeback: the new producer keeps r7 busy
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0); cycle("issue_r7");
      drive(1, 0, 0, 0, 7, 1, 1, 7, 0); cycle("waw_r7_wb");
      check("r7_set_wins", 64'(busy_vec[7]), 64'h1);
      drive(0, 0, 0, 0, 0, 0, 1, 6, 0); cycle("wb_r6");
      drive(0, 0, 0, 0, 0, 0, 1, 7, 0); cycle("wb_r7");
      drive(0, 0, 0, 0, 0, 0, 1, 9, 0); cycle("wb_idle_r9");

      // Destination r0 never becomes busy
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle("issue_r0");
      check("r0_not_busy", 64'(busy_vec), 64'h0);
      drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
      #1;
      check("r0_ready", 64'(bus.issue_ready), 64'h1);
      cycle("use_r0");

      // Watchdog: hold a stall on r3 for TIMEOUT cycles
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0); cycle("issue_r3");
      for (int i = 0; i < TIMEOUT; i++) begin
         drive(1, 3, 0, 0, 8, 0, 0, 0, 0); cycle("stall_r3");
         if (i == TIMEOUT - 2) check("pre_deadlock", 64'(deadlock), 64'h0);
      end
      check("deadlock_set", 64'(deadlock), 64'h1);
      check("deadlock_count", 64'(stall_count), 64'd64);
      check("deadlock_state", 64'(dbg_state), 64'(DEADLOCK));
      drive(1, 3, 0, 0, 8, 0, 0, 0, 0); cycle("stall_sat");
      check("count_saturates", 64'(stall_count), 64'd64);
      drive(1, 3, 0, 0, 8, 0, 1, 3, 0); cycle("deadlock_fire");
      check("deadlock_sticky", 64'(deadlock), 64'h1);
      drive(1, 0, 0, 0, 4, 1, 0, 0, 0); cycle("issue_r4");
      drive(1, 4, 0, 0, 0, 0, 0, 0, 1); cycle("flush");
      check("flush_deadlock", 64'(deadlock), 64'h0);
      check("flush_busy", 64'(busy_vec), 64'h0);

      // Asynchronous reset in the middle of a stall with r4..r7 busy
      for (int r = 4; r < 8; r++) begin
         drive(1, 0, 0, 0, r, 1, 0, 0, 0); cycle("fill");
      end
      check("fill_busy", 64'(busy_vec), 64'hF0);
      drive(1, 4, 0, 0, 0, 0, 0, 0, 0); cycle("pre_reset_stall_a");
      drive(1, 4, 0, 0, 0, 0, 0, 0, 0); cycle("pre_reset_stall_b");
      #2 reset = 1'b0;
      #1;
      check("async.busy_vec", 64'(busy_vec), 64'h0);
      check("async.stall_count", 64'(stall_count), 64'h0);
      check("async.deadlock", 64'(deadlock), 64'h0);
      check("async.stall", 64'(stall), 64'h0);
      check("async.state", 64'(dbg_state), 64'(RUN));
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic over a small register window to force hazards
      for (int n = 0; n < 400; n++) begin
         busy_list.delete();
         for (int r = 0; r < NUM_REGS; r++) if (m_busy[r]) busy_list.push_back(r);
         wbv = 1'b0;
         wbr = int'($urandom_range(0, 7));
         if (busy_list.size() > 0 && $urandom_range(0, 2) != 0) begin
            pick = int'($urandom_range(0, busy_list.size() - 1));
            wbr  = busy_list[pick];
            wbv  = 1'b1;
         end else if ($urandom_range(0, 3) == 0) begin
            wbv = 1'b1;
         end
         drive($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               wbv, wbr, $urandom_range(0, 39) == 0);
         cycle("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_reg_scoreboard_checker
